// File: rtl/seg_display_mux_if.sv
// Digit/control inputs and display pins of the stopwatch seven-segment stage.
interface seg_display_mux_if;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output m10, m1, s10, s1, adj, sel,
        input  seg, an, dp
    );

    modport slave (
        input  m10, m1, s10, s1, adj, sel,
        output seg, an, dp
    );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input
// snapshots and blinking of the digit pair under adjustment.
module seg_display_mux #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    seg_display_mux_if.slave    bus
);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam logic [6:0]  DASH = 7'b0111111;

    typedef enum logic [1:0] {
        DIG_S1  = 2'd0,
        DIG_S10 = 2'd1,
        DIG_M1  = 2'd2,
        DIG_M10 = 2'd3
    } digit_t;

    logic [SW-1:0] scan_cnt;
    digit_t        digit;
    logic [2:0]    snap_m10;
    logic [3:0]    snap_m1;
    logic [2:0]    snap_s10;
    logic [3:0]    snap_s1;
    logic          primed;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          adj_q;
    logic          sel_q;

    logic          scan_last;
    logic          blink_last;
    logic          frame_start;
    logic          blank;
    logic [3:0]    cur_val;
    logic          cur_bad;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = DASH;
        endcase
        return p;
    endfunction

    assign scan_last   = (scan_cnt == SW'(SCAN_DIV - 1));
    assign blink_last  = (blink_cnt == BW'(BLINK_DIV - 1));
    assign frame_start = (digit == DIG_S1) && (scan_cnt == '0);

    always_comb begin
        cur_val = '0;
        cur_bad = 1'b0;
        case (digit)
            DIG_S1:  cur_val = snap_s1;
            DIG_S10: begin cur_val = {1'b0, snap_s10}; cur_bad = (snap_s10 > 3'd5); end
            DIG_M1:  cur_val = snap_m1;
            DIG_M10: begin cur_val = {1'b0, snap_m10}; cur_bad = (snap_m10 > 3'd5); end
            default: cur_val = '0;
        endcase
    end

    // sel_q picks the pair: 1 -> seconds (digits 0/1), 0 -> minutes (digits 2/3)
    assign blank = adj_q && blink_phase && (sel_q ? !digit[1] : digit[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt    <= '0;
            digit       <= DIG_S1;
            snap_m10    <= '0;
            snap_m1     <= '0;
            snap_s10    <= '0;
            snap_s1     <= '0;
            primed      <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            adj_q       <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            primed <= 1'b1;
            adj_q  <= bus.adj;
            sel_q  <= bus.sel;

            if (scan_last) begin
                scan_cnt <= '0;
                digit    <= digit_t'(digit + 2'd1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            // The reset state is itself a frame start, so this also covers the first edge
            if (frame_start || !primed) begin
                snap_m10 <= bus.m10;
                snap_m1  <= bus.m1;
                snap_s10 <= bus.s10;
                snap_s1  <= bus.s1;
            end

            if (adj_q) begin
                if (blink_last) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= '1;
            bus.seg <= '1;
            bus.dp  <= 1'b1;
        end else if (!primed || blank) begin
            bus.an  <= '1;
            bus.seg <= '1;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= ~(4'(1) << digit);
            bus.seg <= cur_bad ? DASH : decode(cur_val);
            bus.dp  <= (digit != DIG_M1);
        end
    end
endmodule

// File: tb/tb_seg_display_mux.sv
// Randomized scoreboard bench for seg_display_mux against a timeline-based
// reference model of the displayed digits.
module tb_seg_display_mux;
    localparam int S    = 4;
    localparam int B    = 8;
    localparam int HMAX = 8192;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    seg_display_mux_if bus();

    seg_display_mux #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    exp_t sb[$];

    logic [2:0] m10_h [HMAX];
    logic [3:0] m1_h  [HMAX];
    logic [2:0] s10_h [HMAX];
    logic [3:0] s1_h  [HMAX];
    logic       adj_h [HMAX];
    logic       sel_h [HMAX];

    function automatic logic [6:0] pattern(input int v, input int maxv);
        if (v > maxv) return 7'b0111111;
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected pins after edge n (n counted from reset release; edge 1 primes).
    function automatic exp_t model(input int n);
        exp_t e;
        int d, f, run, v, maxv;
        logic aq, sq, phase, in_pair;
        e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.n = n;
        if (n <= 1) return e;
        d  = ((n - 1) / S) % 4;
        f  = ((n - 2) / (4 * S)) * (4 * S) + 1;
        aq = adj_h[n-1];
        sq = sel_h[n-1];
        run = 0;
        for (int k = n - 2; k >= 1; k--) begin
            if (!adj_h[k]) break;
            run++;
        end
        phase   = ((run / B) % 2) == 1;
        in_pair = sq ? (d < 2) : (d >= 2);
        if (aq && phase && in_pair) return e;
        case (d)
            0: begin v = int'(s1_h[f]);  maxv = 9; end
            1: begin v = int'(s10_h[f]); maxv = 5; end
            2: begin v = int'(m1_h[f]);  maxv = 9; end
            default: begin v = int'(m10_h[f]); maxv = 5; end
        endcase
        e.an  = ~(4'(1) << d);
        e.seg = pattern(v, maxv);
        e.dp  = (d == 2) ? 1'b0 : 1'b1;
        return e;
    endfunction

    // Stimulus side of the scoreboard: log what the DUT sampled, push the expectation.
    int n = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                n = 0;
                sb.push_back(model(0));
            end else begin
                n++;
                if (n >= HMAX) begin
                    $display("FAIL history_bound n=%0d limit=%0d", n, HMAX);
                    $fatal(1, "history overflow");
                end
                m10_h[n] = bus.m10; m1_h[n] = bus.m1;
                s10_h[n] = bus.s10; s1_h[n] = bus.s1;
                adj_h[n] = bus.adj; sel_h[n] = bus.sel;
                sb.push_back(model(n));
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.an === e.an && bus.seg === e.seg && bus.dp === e.dp)
                    passed++;
                else
                    $display("FAIL pins edge=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             e.n, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic check_off(input string name);
        checks++;
        if (bus.an === 4'b1111 && bus.seg === 7'b1111111 && bus.dp === 1'b1)
            passed++;
        else
            $display("FAIL %s got an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1",
                     name, bus.an, bus.seg, bus.dp);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_off(name);
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d expected completion", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.m10 = 3'd5; bus.m1 = 4'd9; bus.s10 = 3'd3; bus.s1 = 4'd7;
        bus.adj = 1'b0; bus.sel = 1'b0;
        #1 check_off("reset_state");
        step(2);
        rst = 1'b0;

        step(40);                    // static 59:37
        step(6);
        bus.s1 = 4'd2;               // mid-frame change, visible only next frame
        step(40);

        repeat (30) begin
            bus.m10 = 3'($urandom_range(0, 5)); bus.m1 = 4'($urandom_range(0, 9));
            bus.s10 = 3'($urandom_range(0, 5)); bus.s1 = 4'($urandom_range(0, 9));
            step($urandom_range(1, 8));
        end

        bus.adj = 1'b1; bus.sel = 1'b1; step(70);
        bus.sel = 1'b0; step(70);
        bus.sel = 1'b1; step(13);
        bus.adj = 1'b0; step(20);

        bus.s1 = 4'd12; bus.m10 = 3'd6; bus.m1 = 4'd4; bus.s10 = 3'd1;
        step(40);

        async_reset("async_reset_mid_slot");
        step(40);

        repeat (120) begin
            bus.m10 = 3'($urandom_range(0, 7)); bus.m1 = 4'($urandom_range(0, 15));
            bus.s10 = 3'($urandom_range(0, 7)); bus.s1 = 4'($urandom_range(0, 15));
            bus.adj = ($urandom_range(0, 3) != 0);
            bus.sel = 1'($urandom_range(0, 1));
            step($urandom_range(1, 20));
        end

        async_reset("async_reset_random");
        bus.adj = 1'b1;
        step(60);
        step(3);
        checks++;
        if (sb.size() <= 1) passed++;
        else $display("FAIL scoreboard_drain got %0d pending expected <=1", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
